// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall, bubble, flush and PC-select control for load-use, fetch-wait, branch and multi-cycle MDU
module pipe_stall_ctrl #(
  parameter int MDU_CYCLES = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rn,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        id_mdu_start,
  input  logic        id_branch_taken,
  input  logic        imem_ready,
  output logic        wpcir,
  output logic        bubble,
  output logic        flush,
  output logic [1:0]  pcsrc,
  output logic [1:0]  state,
  output logic [15:0] perf_stalls
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, MDU_WAIT = 2'b10, BAD = 2'b11} state_t;
  localparam logic [5:0] CNT_LOAD = 6'(MDU_CYCLES - 1);
  state_t     st;
  logic [5:0] cnt;
  logic       load_use, hold, take_br;
  assign load_use = ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
                    ((id_use_rs & (ex_rn == id_rs)) | (id_use_rt & (ex_rn == id_rt)));
  assign state = st;
  // Stall conditions in RUN take precedence over branch and MDU issue
  always_comb begin
    hold    = (st == RUN) & (load_use | ~imem_ready);
    take_br = (st == RUN) & ~hold & id_branch_taken;
    wpcir   = ~(hold | (st == MDU_WAIT));
    bubble  = (st != RUN) | hold;
    flush   = (st == BOOT) | take_br;
    pcsrc   = {1'b0, take_br};
  end
  // State and MDU wait counter; counter value 0 marks the last wait cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st  <= BOOT;
      cnt <= 6'd0;
    end else begin
      case (st)
        BOOT:     st <= RUN;
        RUN: if (!hold && id_mdu_start) begin
          st  <= MDU_WAIT;
          cnt <= CNT_LOAD;
        end
        MDU_WAIT: if (cnt == 6'd0) st <= RUN; else cnt <= cnt - 6'd1;
        default:  st <= RUN;
      endcase
    end
  end
  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) perf_stalls <= 16'd0;
    else if (!wpcir && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
  end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: randomized and directed checks against a behavioural stall model
module tb_pipe_stall_ctrl;
  localparam int MDU = 8;
  logic clk = 1'b0, clrn = 1'b0;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rn = 0;
  logic id_use_rs = 0, id_use_rt = 0, ex_wreg = 0, ex_m2reg = 0;
  logic id_mdu_start = 0, id_branch_taken = 0, imem_ready = 1;
  logic wpcir, bubble, flush;
  logic [1:0] pcsrc, state;
  logic [15:0] perf_stalls;
  int checks = 0, errors = 0;
  int m_boot = 1, m_wait = 0, m_perf = 0;
  bit quiet = 0;

  pipe_stall_ctrl #(.MDU_CYCLES(MDU)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rn(ex_rn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
    .id_mdu_start(id_mdu_start), .id_branch_taken(id_branch_taken), .imem_ready(imem_ready),
    .wpcir(wpcir), .bubble(bubble), .flush(flush), .pcsrc(pcsrc), .state(state),
    .perf_stalls(perf_stalls));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    id_rs = 0; id_rt = 0; ex_rn = 0; id_use_rs = 0; id_use_rt = 0;
    ex_wreg = 0; ex_m2reg = 0; id_mdu_start = 0; id_branch_taken = 0; imem_ready = 1;
  endtask

  // One clock: inputs already applied; check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    int ew, eb, ef, ep, es, hz;
    #1;
    hz = 0;
    if (m_boot) begin ew = 1; eb = 1; ef = 1; ep = 0; es = 0; end
    else if (m_wait > 0) begin ew = 0; eb = 1; ef = 0; ep = 0; es = 2; end
    else begin
      hz = int'(!imem_ready) | int'(ex_wreg && ex_m2reg && ex_rn != 0 &&
           ((id_use_rs && ex_rn == id_rs) || (id_use_rt && ex_rn == id_rt)));
      es = 1;
      if (hz) begin ew = 0; eb = 1; ef = 0; ep = 0; end
      else begin ew = 1; eb = 0; ef = int'(id_branch_taken); ep = int'(id_branch_taken); end
    end
    if (!quiet) begin
      chk("state", 32'(state), es);
      chk("wpcir", 32'(wpcir), ew);
      chk("bubble", 32'(bubble), eb);
      chk("flush", 32'(flush), ef);
      chk("pcsrc", 32'(pcsrc), ep);
      chk("perf", 32'(perf_stalls), m_perf);
    end
    @(posedge clk);
    if (!ew && m_perf < 65535) m_perf++;
    if (m_boot) m_boot = 0;
    else if (m_wait > 0) m_wait--;
    else if (!hz && id_mdu_start) m_wait = MDU;
    @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 clrn = 0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_perf", 32'(perf_stalls), 0);
    chk("rst_wpcir", 32'(wpcir), 1);
    chk("rst_bubble", 32'(bubble), 1);
    chk("rst_flush", 32'(flush), 1);
    m_boot = 1; m_wait = 0; m_perf = 0;
    @(negedge clk);
    clrn = 1;
  endtask

  initial begin
    clear_in();
    @(negedge clk);
    reset_mid();
    step();
    step();
    step();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 5; id_rs = 5; id_use_rs = 1; id_branch_taken = 1;
    step();
    ex_wreg = 0; ex_m2reg = 0;
    step();
    id_branch_taken = 0;
    step();
    ex_wreg = 1; ex_m2reg = 1; ex_rn = 0; id_rs = 0; id_branch_taken = 1;
    step();
    clear_in();
    id_mdu_start = 1;
    step();
    id_mdu_start = 0;
    repeat (MDU + 2) step();
    imem_ready = 0;
    repeat (3) step();
    imem_ready = 1;
    repeat (2) step();
    id_mdu_start = 1;
    step();
    id_mdu_start = 0;
    repeat (3) step();
    reset_mid();
    step();
    step();
    repeat (2000) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rn = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      ex_wreg = 1'($urandom);
      ex_m2reg = 1'($urandom);
      id_branch_taken = 1'($urandom);
      id_mdu_start = ($urandom_range(0, 9) == 0);
      imem_ready = ($urandom_range(0, 4) != 0);
      step();
    end
    clear_in();
    repeat (MDU + 1) step();
    imem_ready = 0;
    quiet = 1;
    repeat (65540) step();
    quiet = 0;
    chk("perf_sat", 32'(perf_stalls), 32'hFFFF);
    step();
    step();
    chk("perf_hold", 32'(perf_stalls), 32'hFFFF);
    imem_ready = 1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter: MDU_CYCLES, 8, number of stall cycles after a multi-cycle multiply/divide issues; legal range 1..63.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 clrn  input  1  reset, asynchronous, active-low.
REQ-004 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 ex_rn  input  5  destination register of the instruction in EX.
REQ-007 ex_wreg, ex_m2reg  input  1 each  EX instruction writes a register / is a load.
REQ-008 id_mdu_start  input  1  ID instruction is a multi-cycle multiply/divide.
REQ-009 id_branch_taken  input  1  ID instruction is a taken branch or jump.
REQ-010 imem_ready  input  1  instruction-fetch data valid this cycle.
REQ-011 wpcir  output  1  write enable for the PC register and the IF/ID register.
REQ-012 bubble  output  1  insert a NOP into the ID/EX register.
REQ-013 flush  output  1  clear IF/ID at the next edge.
REQ-014 pcsrc  output  2  next-PC select: 00 sequential, 01 branch target; 10/11 never driven.
REQ-015 state  output  2  FSM state: 00 BOOT, 01 RUN, 10 MDU_WAIT.
REQ-016 perf_stalls  output  16  count of cycles with wpcir=0.

Function
REQ-017 FSM states: BOOT, RUN, MDU_WAIT; encoding per REQ-015; 11 unreachable, and if entered it SHALL return to RUN on the next edge.
REQ-018 BOOT lasts exactly one cycle after reset release: wpcir=1, bubble=1, flush=1, pcsrc=00; next state RUN.
REQ-019 RUN: load_use = ex_wreg & ex_m2reg & (ex_rn!=0) & ((id_use_rs & ex_rn==id_rs) | (id_use_rt & ex_rn==id_rt)).
REQ-020 RUN priority 1: load_use or !imem_ready -> wpcir=0, bubble=1, flush=0, pcsrc=00; state stays RUN; id_mdu_start and id_branch_taken are ignored this cycle.
REQ-021 RUN priority 2: otherwise, id_branch_taken -> wpcir=1, pcsrc=01, flush=1, bubble=0.
REQ-022 RUN priority 2: otherwise, id_mdu_start -> wpcir=1, bubble=0; next state MDU_WAIT; counter loaded with MDU_CYCLES-1; honoured together with REQ-021 when both inputs are asserted.
REQ-023 RUN with no condition asserted: wpcir=1, bubble=0, flush=0, pcsrc=00.
REQ-024 MDU_WAIT: wpcir=0, bubble=1, flush=0, pcsrc=00; all hazard, branch and imem inputs ignored.
REQ-025 MDU_WAIT counter decrements by 1 each cycle; the cycle in which the counter equals 0 is the last stall cycle; next state RUN. MDU_WAIT therefore lasts exactly MDU_CYCLES cycles.
REQ-026 A single load-use stall lasts one cycle, because the load leaves EX; back-to-back stall causes SHALL each be evaluated independently per cycle.
REQ-027 perf_stalls increments by 1 on each rising edge at which wpcir=0, saturating at 16'hFFFF (no wrap).
REQ-028 wpcir, bubble, flush and pcsrc are combinational functions of state and inputs; state, counter and perf_stalls are registered.

Reset
REQ-029 clrn=0 asynchronously forces state=BOOT, counter=0, perf_stalls=0; outputs take BOOT values per REQ-018 while clrn=0.
REQ-030 Reset asserted during MDU_WAIT aborts the wait immediately; no residual stall after release beyond BOOT.

Verification
REQ-031 Reset release, imem_ready=1, no hazards -> cycle 0: state=00, wpcir=1, flush=1; cycle 1 onward: state=01, wpcir=1, bubble=0.
REQ-032 RUN, ex_wreg=1, ex_m2reg=1, ex_rn=5, id_rs=5, id_use_rs=1, id_branch_taken=1 -> wpcir=0, bubble=1, pcsrc=00 for 1 cycle; perf_stalls +1; with EX cleared next cycle -> pcsrc=01, flush=1.
REQ-033 Same as REQ-032 but ex_rn=0 -> no stall (wpcir=1).
REQ-034 MDU_CYCLES=8, id_mdu_start=1 in RUN -> issue cycle wpcir=1, then exactly 8 cycles with state=10, wpcir=0, bubble=1, then state=01; perf_stalls +8.
REQ-035 imem_ready=0 for 3 cycles in RUN -> wpcir=0 for exactly those 3 cycles; then normal flow.
REQ-036 clrn pulsed low at MDU_WAIT cycle 3 -> state=00 immediately, perf_stalls=0; RUN one cycle after release; perf_stalls preloaded to FFFF with a further stall -> stays FFFF.
